sort_frame_packer: RTL and testbench
====================================

Name: sort_frame_packer

Overview:
- Input stage that sits directly upstream of the 8-lane, 8-bit sorter.
- Accepts a serial stream of samples over a valid/ready handshake and packs each group of N samples into one N*W-bit frame.
- Holds the frame stable on the sorter's 64-bit input bus and issues a frame_valid/frame_ready handshake to the sorter-side control.
- Lane order: first accepted sample goes to lane 0, bits [W-1:0]; sample k goes to bits [k*W+W-1 : k*W].

Parameters:
- W, 8, sample width in bits.
- N, 8, samples per frame; frame width N*W = 64 by default.
- CW, 16, width of the frame counter.
- PAD_VAL, 8'h00, fill value for unused lanes on flush (FLUSH_EN builds only).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  W  sample input.
- in_valid  in  1  sample present.
- in_ready  out  1  packer can take the sample this cycle.
- frame_data  out  N*W  packed frame; drives the sorter input bus.
- frame_valid  out  1  frame_data holds a complete frame.
- frame_ready  in  1  consumer takes the frame this cycle.
- frame_cnt  out  CW  number of frames handed off; wraps at 2^CW.
- fill  out  clog2(N)  samples held in the partial frame.
- flush  in  1  FLUSH_EN builds only: request to emit the partial frame.

Behaviour:
- Reset (async assert, sync release): acc=0, fill=0, frame_data=0, frame_valid=0, frame_cnt=0, flush_pend=0. During reset in_ready=0.
- Sample accept: in_valid && in_ready at an edge. in_data is written into lane fill of acc, then fill increments.
- in_ready = (fill != N-1) || !frame_valid || frame_ready. Throughout, flush_pend=0 is also required.
- Frame complete: the sample accepted with fill==N-1 moves {in_data, acc lanes 0..N-2} into frame_data. On that same edge, frame_valid=1, fill=0 and acc=0.
- Latency: last sample accepted at edge k gives frame_valid=1 from edge k onward (visible in cycle k+1).
- Throughput: one sample per cycle, no bubbles, while frame_ready stays high.
- Handoff: frame_valid && frame_ready at an edge clears frame_valid and increments frame_cnt.
  - If a new frame completes on the same edge, frame_valid stays 1 and frame_data takes the new frame.
  - frame_cnt still increments once for the handoff.
- Stability: while frame_valid && !frame_ready, frame_data and frame_valid hold.
- Back-pressure: if the output frame is held, samples are still accepted into lanes 0..N-2. The packer stalls only on the last lane.
- frame_data keeps its last value after a handoff; it is not cleared.
- frame_cnt wraps from 2^CW-1 to 0 with no flag.
- in_valid low: no state change except the handoff logic.
- Reset mid-frame discards the partial acc and any held frame.

Optional Feature:
- Macro: SORT_PACKER_FLUSH_EN.
- Defined: flush port present.
  - flush at an edge with fill>0 or with a sample being accepted sets flush_pend.
  - While flush_pend=1, in_ready=0.
  - Once the output slot is free or draining, {PAD_VAL in lanes fill..N-1, acc} transfers as a frame; fill=0 and flush_pend clears.
  - Flush with fill==0 and no accept is ignored.
  - If the sample accepted on the flush edge completes the frame, the flush has no further effect.
- Undefined: no flush port, no flush_pend register. The PAD_VAL parameter is unused.

Decomposition:
- Package sort_pkg holds SORT_W=8, SORT_N=8, SORT_FRAME_W=64 and the lane-slice helper function. The sorter should use the same constants.
- One natural sub-module: sort_frame_slot, a single-entry valid/ready output register (load, hold, drain-and-reload same cycle) with frame_cnt.
- The accumulator and fill counter stay in the top module.

Test Plan:
- Samples 1..8 fed back-to-back, frame_ready=1 → one cycle after the 8th accept: frame_data=64'h0807060504030201, frame_valid=1. frame_cnt=1 after the handoff.
- 24 samples with in_valid held high and frame_ready=1 → three frames, no in_ready deassertion, frame_cnt=3.
- frame_ready=0 after frame 1, 8 more samples offered → 7 accepted, in_ready=0 on the 8th, frame_data stays 64'h0807060504030201. Raising frame_ready lets the 8th sample in and loads frame 2 on the same edge.
- rst_n pulsed low asynchronously (mid-clock) after 5 samples with frame_valid=1 → all outputs 0 immediately. The next 8 samples form a clean frame.
- frame_cnt preloaded by running 65535 frames (or CW=4 with 15 frames), then one more frame → frame_cnt wraps to 0.
- SORT_PACKER_FLUSH_EN: 3 samples AA,BB,CC then flush → frame_data=64'h0000000000CCBBAA, fill=0, in_ready low for exactly the transfer cycle.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants for the 8-lane, 8-bit sorter datapath and its input packer.
// Also provides the lane-slice helper used to pick one sample out of a frame.
package sort_pkg;

    localparam int SORT_W       = 8;
    localparam int SORT_N       = 8;
    localparam int SORT_FRAME_W = SORT_W * SORT_N;

    function automatic logic [SORT_W-1:0] lane_slice(
        input logic [SORT_FRAME_W-1:0] frame,
        input int unsigned             lane
    );
        return frame[lane*SORT_W +: SORT_W];
    endfunction

endpackage

// File: rtl/sort_frame_packer_if.sv
// Sample-in and frame-out handshake bundle of the sorter input packer.
// slave = packer side, master = upstream source plus sorter-side consumer.
interface sort_frame_packer_if
    import sort_pkg::*;
#(
    parameter int W = SORT_W,
    parameter int N = SORT_N
);
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] frame_data;
    logic           frame_valid;
    logic           frame_ready;

    modport master (
        output in_data, in_valid, frame_ready,
        input  in_ready, frame_data, frame_valid
    );

    modport slave (
        input  in_data, in_valid, frame_ready,
        output in_ready, frame_data, frame_valid
    );
endinterface

// File: rtl/sort_frame_slot.sv
// Single-entry valid/ready output register holding one packed frame.
// Supports drain-and-reload on the same edge and counts completed handoffs.
module sort_frame_slot #(
    parameter int FW = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [FW-1:0] load_data,
    input  logic          frame_ready,
    output logic [FW-1:0] frame_data,
    output logic          frame_valid,
    output logic [CW-1:0] frame_cnt,
    output logic          slot_free
);
    logic [FW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          handoff;

    assign handoff   = valid_q && frame_ready;
    assign slot_free = !valid_q || frame_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (handoff) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CW'(1);
        end
        // A load on the handoff edge overrides the clear, keeping the slot full.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign frame_cnt   = cnt_q;
endmodule

// File: rtl/sort_frame_packer.sv
// Packs a serial sample stream into N-lane frames for the sorter input bus.
// Define SORT_PACKER_FLUSH_EN to add the flush port that emits a padded partial frame.
module sort_frame_packer
    import sort_pkg::*;
#(
    parameter int W  = SORT_W,
    parameter int N  = SORT_N,
    parameter int CW = 16
`ifdef SORT_PACKER_FLUSH_EN
    ,
    parameter logic [W-1:0] PAD_VAL = '0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sort_frame_packer_if.slave   bus,
    output logic [CW-1:0]        frame_cnt,
    output logic [$clog2(N)-1:0] fill
`ifdef SORT_PACKER_FLUSH_EN
    ,
    input  logic                 flush
`endif
);
    localparam int                FILL_W = $clog2(N);
    localparam logic [FILL_W-1:0] LAST   = FILL_W'(N - 1);

    logic [W-1:0]      acc_q [N];
    logic [W-1:0]      acc_d [N];
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              run_q;
    logic              in_ready;
    logic              accept;
    logic              last_lane;
    logic              slot_free;
    logic              load;
    logic [N*W-1:0]    load_data;
    logic [N*W-1:0]    full_frame;

    assign last_lane = (fill_q == LAST);
    assign accept    = bus.in_valid && in_ready;

    // The completing sample goes straight to the top lane, bypassing acc.
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_full
        assign full_frame[gi*W +: W] = acc_q[gi];
    end
    assign full_frame[(N-1)*W +: W] = bus.in_data;

`ifdef SORT_PACKER_FLUSH_EN
    logic           pend_q, pend_d;
    logic [N*W-1:0] pad_frame;

    for (genvar gi = 0; gi < N; gi++) begin : g_pad
        assign pad_frame[gi*W +: W] = (FILL_W'(gi) < fill_q) ? acc_q[gi] : PAD_VAL;
    end

    assign in_ready = run_q && !pend_q && (!last_lane || slot_free);
`else
    assign in_ready = run_q && (!last_lane || slot_free);
`endif

    always_comb begin
        acc_d     = acc_q;
        fill_d    = fill_q;
        load      = 1'b0;
        load_data = full_frame;
        if (accept) begin
            if (last_lane) begin
                load   = 1'b1;
                fill_d = '0;
                for (int i = 0; i < N; i++) acc_d[i] = '0;
            end else begin
                acc_d[fill_q] = bus.in_data;
                fill_d        = fill_q + FILL_W'(1);
            end
        end
`ifdef SORT_PACKER_FLUSH_EN
        pend_d = pend_q;
        if (flush && !pend_q && (fill_q != '0 || accept) && !(accept && last_lane))
            pend_d = 1'b1;
        // in_ready is low while pending, so this never collides with an accept.
        if (pend_q && slot_free) begin
            load      = 1'b1;
            load_data = pad_frame;
            fill_d    = '0;
            pend_d    = 1'b0;
            for (int i = 0; i < N; i++) acc_d[i] = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) acc_q[i] <= '0;
            fill_q <= '0;
            run_q  <= 1'b0;
`ifdef SORT_PACKER_FLUSH_EN
            pend_q <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            run_q  <= 1'b1;
`ifdef SORT_PACKER_FLUSH_EN
            pend_q <= pend_d;
`endif
        end
    end

    sort_frame_slot #(
        .FW (N * W),
        .CW (CW)
    ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_data   (load_data),
        .frame_ready (bus.frame_ready),
        .frame_data  (bus.frame_data),
        .frame_valid (bus.frame_valid),
        .frame_cnt   (frame_cnt),
        .slot_free   (slot_free)
    );

    assign bus.in_ready = in_ready;
    assign fill         = fill_q;
endmodule

// File: tb/tb_sort_frame_packer.sv
// Self-checking bench for sort_frame_packer: vector table plus handoff scoreboard.
// Define SORT_PACKER_FLUSH_EN to also exercise the flush sequence.
module tb_sort_frame_packer;
    import sort_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] frame_cnt;
    logic [2:0]    fill;
`ifdef SORT_PACKER_FLUSH_EN
    logic          flush;
`endif

    sort_frame_packer_if #(.W(SORT_W), .N(SORT_N)) bus ();

    sort_frame_packer #(
        .W  (SORT_W),
        .N  (SORT_N),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .fill      (fill)
`ifdef SORT_PACKER_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  step;
        logic [63:0] exp;
    } vec_t;

    vec_t          vecs [5];
    logic [63:0]   exp_q [$];
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard: every handoff must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && bus.frame_valid && bus.frame_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handoff: unexpected frame %h, none expected", bus.frame_data);
            end else begin
                chk("handoff", bus.frame_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] d, inout int stalls);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            stalls++;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] f, inout int stalls);
        for (int k = 0; k < 8; k++) send(f[k*8 +: 8], stalls);
    endtask

    initial begin
        int          stalls;
        logic [63:0] fa;
        logic [63:0] fb;
        logic [63:0] fr;

        vecs[0] = '{8'h01, 8'h01, 64'h0807060504030201};
        vecs[1] = '{8'h10, 8'h10, 64'h8070605040302010};
        vecs[2] = '{8'hFF, 8'hFF, 64'hF8F9FAFBFCFDFEFF};
        vecs[3] = '{8'hA5, 8'h00, 64'hA5A5A5A5A5A5A5A5};
        vecs[4] = '{8'hF0, 8'h11, 64'h67564534231201F0};

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.frame_ready = 1'b0;
`ifdef SORT_PACKER_FLUSH_EN
        flush           = 1'b0;
`endif
        stalls          = 0;
        #3;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        chk("rst_frame_data", bus.frame_data, 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Samples 1..8, latency and first handoff.
        bus.frame_ready = 1'b1;
        exp_q.push_back(64'h0807060504030201);
        for (int k = 1; k <= 8; k++) send(8'(k), stalls);
        bus.in_valid = 1'b0;
        chk("t1_valid", 64'(bus.frame_valid), 64'd1);
        chk("t1_data", bus.frame_data, 64'h0807060504030201);
        @(posedge clk); #1;
        chk("t1_valid_clr", 64'(bus.frame_valid), 64'd0);
        chk("t1_cnt", 64'(frame_cnt), 64'd1);
        exp_cnt = 4'd1;

        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vecs[v].exp);
            for (int k = 0; k < 8; k++) send(8'(vecs[v].base + 8'(k) * vecs[v].step), stalls);
            bus.in_valid = 1'b0;
            chk("vec_data", bus.frame_data, vecs[v].exp);
            @(posedge clk); #1;
            exp_cnt++;
        end
        chk("vec_cnt", 64'(frame_cnt), 64'(exp_cnt));

        // 24 back-to-back samples with in_valid held high.
        stalls = 0;
        for (int f = 0; f < 3; f++) begin
            fr = {$urandom, $urandom};
            exp_q.push_back(fr);
            send_frame(fr, stalls);
            exp_cnt++;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("burst_stalls", 64'(stalls), 64'd0);
        chk("burst_cnt", 64'(frame_cnt), 64'(exp_cnt));

        // Back-pressure: stall only on the last lane, then drain-and-reload.
        bus.frame_ready = 1'b0;
        fa = 64'h0807060504030201;
        fb = 64'h1817161514131211;
        exp_q.push_back(fa);
        exp_q.push_back(fb);
        stalls = 0;
        send_frame(fa, stalls);
        for (int k = 0; k < 7; k++) send(fb[k*8 +: 8], stalls);
        chk("bp_seven_accepted", 64'(stalls), 64'd0);
        chk("bp_fill", 64'(fill), 64'd7);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h18;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            chk("bp_hold_data", bus.frame_data, fa);
        end
        chk("bp_lane7", 64'(lane_slice(bus.frame_data, 7)), 64'h08);
        @(posedge clk); #1;
        bus.frame_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_high", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_cnt++;
        chk("bp_reload_valid", 64'(bus.frame_valid), 64'd1);
        chk("bp_reload_data", bus.frame_data, fb);
        chk("bp_reload_cnt", 64'(frame_cnt), 64'(exp_cnt));
        @(posedge clk); #1;
        exp_cnt++;
        chk("bp_drain_cnt", 64'(frame_cnt), 64'(exp_cnt));

        // Asynchronous reset with a held frame and a partial frame.
        bus.frame_ready = 1'b0;
        send_frame({$urandom, $urandom}, stalls);
        for (int k = 0; k < 5; k++) send(8'($urandom), stalls);
        bus.in_valid = 1'b0;
        chk("pre_rst_fill", 64'(fill), 64'd5);
        chk("pre_rst_valid", 64'(bus.frame_valid), 64'd1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.frame_valid), 64'd0);
        chk("mid_rst_data", bus.frame_data, 64'd0);
        chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
        chk("mid_rst_fill", 64'(fill), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.frame_ready = 1'b1;
        fr = {$urandom, $urandom};
        exp_q.push_back(fr);
        send_frame(fr, stalls);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        exp_cnt = 4'd1;
        chk("post_rst_cnt", 64'(frame_cnt), 64'(exp_cnt));

        // Counter wrap: run to 15, then one more frame.
        while (exp_cnt != 4'hF) begin
            fr = {$urandom, $urandom};
            exp_q.push_back(fr);
            send_frame(fr, stalls);
            exp_cnt++;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("cnt_max", 64'(frame_cnt), 64'hF);
        fr = {$urandom, $urandom};
        exp_q.push_back(fr);
        send_frame(fr, stalls);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        exp_cnt++;
        chk("cnt_wrap", 64'(frame_cnt), 64'(exp_cnt));

`ifdef SORT_PACKER_FLUSH_EN
        exp_q.push_back(64'h0000000000CCBBAA);
        send(8'hAA, stalls);
        send(8'hBB, stalls);
        send(8'hCC, stalls);
        bus.in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("flush_fill_pending", 64'(fill), 64'd3);
        @(posedge clk); #1;
        chk("flush_valid", 64'(bus.frame_valid), 64'd1);
        chk("flush_data", bus.frame_data, 64'h0000000000CCBBAA);
        chk("flush_fill", 64'(fill), 64'd0);
        chk("flush_in_ready_back", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        exp_cnt++;
        chk("flush_cnt", 64'(frame_cnt), 64'(exp_cnt));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_empty_ignored", 64'(bus.in_ready), 64'd1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
